// File: rtl/nexys2_flash_sequencer.sv
// Command-level initiator for the Nexys2 flash controller port 1: expands host
// read/program/erase/status requests into CFI command word bus operations.
module nexys2_flash_sequencer #(
    parameter logic [23:0] POLL_LIMIT = 24'd2000000,
    parameter logic [3:0]  GAP_CYCLES = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  host_cmd,
    input  logic [22:0] host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_start,
    output logic        host_busy,
    output logic        host_done,
    output logic [15:0] host_rdata,
    output logic        host_error,
    output logic        host_timeout,
    output logic [22:0] m_address,
    output logic [15:0] m_to_mem,
    input  logic [15:0] m_from_mem,
    output logic        m_req,
    output logic        m_wren,
    input  logic        m_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_EVAL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] CMD_READ   = 2'b00;
    localparam logic [1:0] CMD_PROG   = 2'b01;
    localparam logic [1:0] CMD_ERASE  = 2'b10;
    localparam logic [1:0] CMD_STATUS = 2'b11;

    logic [2:0]  state_r;
    logic [1:0]  cmd_r;
    logic [22:0] addr_r;
    logic [15:0] wdata_r;
    logic [3:0]  step_r;
    logic        array_mode_r;
    logic [23:0] poll_cnt_r;
    logic [3:0]  gap_cnt_r;
    logic [15:0] rd_r;

    logic [3:0]  poll_step_s;
    logic [23:0] poll_next_s;
    logic        poll_ready_s;
    logic        poll_err_s;
    logic        poll_last_s;
    logic [16:0] op_s;

    // Bus word for a sequence step as {wren, data}; read steps carry zero data.
    function automatic logic [16:0] op_word(input logic [1:0] cmd, input logic [3:0] step,
                                            input logic [15:0] wdata);
        logic [16:0] w;
        w = {1'b0, 16'h0000};
        case (cmd)
            CMD_READ: begin
                case (step)
                    4'd0:    w = {1'b1, 16'h00FF};
                    default: w = {1'b0, 16'h0000};
                endcase
            end
            CMD_PROG: begin
                case (step)
                    4'd0:    w = {1'b1, 16'h0040};
                    4'd1:    w = {1'b1, wdata};
                    4'd2:    w = {1'b0, 16'h0000};
                    4'd3:    w = {1'b1, 16'h0050};
                    default: w = {1'b1, 16'h00FF};
                endcase
            end
            CMD_ERASE: begin
                case (step)
                    4'd0:    w = {1'b1, 16'h0060};
                    4'd1:    w = {1'b1, 16'h00D0};
                    4'd2:    w = {1'b1, 16'h0020};
                    4'd3:    w = {1'b1, 16'h00D0};
                    4'd4:    w = {1'b0, 16'h0000};
                    4'd5:    w = {1'b1, 16'h0050};
                    default: w = {1'b1, 16'h00FF};
                endcase
            end
            CMD_STATUS: begin
                case (step)
                    4'd0:    w = {1'b1, 16'h0070};
                    default: w = {1'b0, 16'h0000};
                endcase
            end
            default: w = {1'b0, 16'h0000};
        endcase
        return w;
    endfunction

    // Status-register decode of the last read and saturating poll count.
    always_comb begin
        poll_step_s  = (cmd_r == CMD_PROG) ? 4'd2 : 4'd4;
        poll_next_s  = (poll_cnt_r < POLL_LIMIT) ? (poll_cnt_r + 24'd1) : poll_cnt_r;
        poll_ready_s = rd_r[7];
        poll_err_s   = rd_r[5] | rd_r[4] | rd_r[3] | rd_r[1];
        poll_last_s  = (poll_next_s >= POLL_LIMIT);
        op_s         = op_word(cmd_r, step_r, wdata_r);
    end

    // Sequencer FSM: one bus operation per step, with a mandatory request gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            cmd_r        <= 2'b00;
            addr_r       <= 23'd0;
            wdata_r      <= 16'h0000;
            step_r       <= 4'd0;
            array_mode_r <= 1'b0;
            poll_cnt_r   <= 24'd0;
            gap_cnt_r    <= 4'd0;
            rd_r         <= 16'h0000;
            host_busy    <= 1'b0;
            host_done    <= 1'b0;
            host_rdata   <= 16'h0000;
            host_error   <= 1'b0;
            host_timeout <= 1'b0;
            m_address    <= 23'd0;
            m_to_mem     <= 16'h0000;
            m_req        <= 1'b0;
            m_wren       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    host_done <= 1'b0;
                    if (host_start) begin
                        cmd_r        <= host_cmd;
                        addr_r       <= host_addr;
                        wdata_r      <= host_wdata;
                        step_r       <= ((host_cmd == CMD_READ) && array_mode_r) ? 4'd1 : 4'd0;
                        poll_cnt_r   <= 24'd0;
                        host_busy    <= 1'b1;
                        host_error   <= 1'b0;
                        host_timeout <= 1'b0;
                        state_r      <= S_LOAD;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    m_address <= addr_r;
                    m_wren    <= op_s[16];
                    m_to_mem  <= op_s[15:0];
                    m_req     <= 1'b1;
                    state_r   <= S_REQ;
                end
                S_REQ: begin
                    if (m_ready) begin
                        m_req     <= 1'b0;
                        rd_r      <= m_wren ? rd_r : m_from_mem;
                        gap_cnt_r <= GAP_CYCLES - 4'd1;
                        state_r   <= S_GAP;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r <= S_EVAL;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                S_EVAL: begin
                    case (cmd_r)
                        CMD_READ: begin
                            array_mode_r <= 1'b1;
                            if (step_r == 4'd0) begin
                                step_r  <= 4'd1;
                                state_r <= S_LOAD;
                            end else begin
                                host_rdata <= rd_r;
                                host_done  <= 1'b1;
                                state_r    <= S_DONE;
                            end
                        end
                        CMD_STATUS: begin
                            if (step_r == 4'd0) begin
                                step_r  <= 4'd1;
                                state_r <= S_LOAD;
                            end else begin
                                host_rdata   <= {8'h00, rd_r[7:0]};
                                array_mode_r <= 1'b0;
                                host_done    <= 1'b1;
                                state_r      <= S_DONE;
                            end
                        end
                        default: begin
                            if (step_r == poll_step_s) begin
                                // Error path inserts the clear-status write before 0x00FF.
                                poll_cnt_r <= poll_next_s;
                                state_r    <= S_LOAD;
                                if (poll_ready_s) begin
                                    host_rdata <= {8'h00, rd_r[7:0]};
                                    host_error <= poll_err_s;
                                    step_r     <= poll_err_s ? (step_r + 4'd1) : (step_r + 4'd2);
                                end else if (poll_last_s) begin
                                    host_rdata   <= {8'h00, rd_r[7:0]};
                                    host_error   <= 1'b1;
                                    host_timeout <= 1'b1;
                                    step_r       <= step_r + 4'd2;
                                end else begin
                                    step_r <= step_r;
                                end
                            end else if (step_r == (poll_step_s + 4'd2)) begin
                                array_mode_r <= 1'b1;
                                host_done    <= 1'b1;
                                state_r      <= S_DONE;
                            end else begin
                                step_r  <= step_r + 4'd1;
                                state_r <= S_LOAD;
                            end
                        end
                    endcase
                end
                S_DONE: begin
                    host_done <= 1'b0;
                    host_busy <= 1'b0;
                    state_r   <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nexys2_flash_sequencer.sv
// Randomized self-checking bench: a flash bus responder logs every operation and
// a list-building reference model predicts the command sequence and results.
module tb_nexys2_flash_sequencer;

    localparam logic [23:0] POLL = 24'd5;
    localparam logic [3:0]  GAP  = 4'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  host_cmd;
    logic [22:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_start;
    logic        host_busy, host_done, host_error, host_timeout;
    logic [15:0] host_rdata;
    logic [22:0] m_address;
    logic [15:0] m_to_mem, m_from_mem;
    logic        m_req, m_wren, m_ready;

    nexys2_flash_sequencer #(.POLL_LIMIT(POLL), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .host_cmd(host_cmd), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_start(host_start), .host_busy(host_busy), .host_done(host_done),
        .host_rdata(host_rdata), .host_error(host_error), .host_timeout(host_timeout),
        .m_address(m_address), .m_to_mem(m_to_mem), .m_from_mem(m_from_mem),
        .m_req(m_req), .m_wren(m_wren), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Flash responder state: read-response queue, op log, handshake delay.
    logic [15:0] rsp_q[$];
    logic [39:0] log_q[$];
    int          dly = 0;
    bit          model_array = 1'b0;

    initial begin
        int          cnt;
        int          low_cnt;
        bit          active;
        bit          stable;
        bit          rdy_given;
        logic [39:0] snap;
        m_ready = 1'b0;
        m_from_mem = 16'h0000;
        cnt = 0; low_cnt = 100; active = 1'b0; stable = 1'b1; rdy_given = 1'b0; snap = 40'd0;
        forever begin
            @(negedge clk);
            if (rdy_given) begin
                check_val("req_fall_after_ready", 40'(m_req), 40'd0);
                rdy_given = 1'b0;
            end
            if (m_req === 1'b1) begin
                if (!active) begin
                    check_val("req_gap", 40'(low_cnt >= int'(GAP)), 40'd1);
                    active = 1'b1;
                    stable = 1'b1;
                    low_cnt = 0;
                    cnt = dly;
                    snap = {m_wren, m_address, m_to_mem};
                    log_q.push_back({m_wren, m_address, m_wren ? m_to_mem : 16'h0000});
                    if (!m_wren) begin
                        if (rsp_q.size() > 0) m_from_mem = rsp_q.pop_front();
                        else m_from_mem = 16'h0000;
                    end
                end else if ({m_wren, m_address, m_to_mem} !== snap) begin
                    stable = 1'b0;
                end
                if (cnt == 0) begin
                    m_ready = 1'b1;
                    rdy_given = 1'b1;
                end else begin
                    cnt--;
                    m_ready = 1'b0;
                end
            end else begin
                if (active) begin
                    check_val("bus_stable", 40'(stable), 40'd1);
                    active = 1'b0;
                end
                m_ready = 1'b0;
                if (low_cnt < 1000) low_cnt++;
            end
        end
    end

    function automatic logic [15:0] next_rsp(inout logic [15:0] q[$]);
        logic [15:0] v;
        if (q.size() > 0) v = q.pop_front();
        else v = 16'h0000;
        return v;
    endfunction

    // Predicts the op list and results from the command rules, then runs the DUT.
    task automatic run_op(input logic [1:0] cmd, input logic [22:0] a, input logic [15:0] wd,
                          input bit inject);
        logic [15:0] mq[$];
        logic [39:0] eq[$];
        logic [15:0] v, exp_rd;
        bit          e, t, fin, seen;
        mq = rsp_q;
        e = 1'b0; t = 1'b0; fin = 1'b0; exp_rd = 16'h0000;
        log_q.delete();
        case (cmd)
            2'b00: begin
                if (!model_array) eq.push_back({1'b1, a, 16'h00FF});
                eq.push_back({1'b0, a, 16'h0000});
                exp_rd = next_rsp(mq);
                model_array = 1'b1;
            end
            2'b11: begin
                eq.push_back({1'b1, a, 16'h0070});
                eq.push_back({1'b0, a, 16'h0000});
                v = next_rsp(mq);
                exp_rd = {8'h00, v[7:0]};
                model_array = 1'b0;
            end
            default: begin
                if (cmd == 2'b01) begin
                    eq.push_back({1'b1, a, 16'h0040});
                    eq.push_back({1'b1, a, wd});
                end else begin
                    eq.push_back({1'b1, a, 16'h0060});
                    eq.push_back({1'b1, a, 16'h00D0});
                    eq.push_back({1'b1, a, 16'h0020});
                    eq.push_back({1'b1, a, 16'h00D0});
                end
                for (int k = 0; k < int'(POLL) && !fin; k++) begin
                    eq.push_back({1'b0, a, 16'h0000});
                    v = next_rsp(mq);
                    if (v[7]) begin
                        fin = 1'b1;
                        exp_rd = {8'h00, v[7:0]};
                        if ((v & 16'h003A) != 16'h0000) begin
                            e = 1'b1;
                            eq.push_back({1'b1, a, 16'h0050});
                        end
                    end else if (k == int'(POLL) - 1) begin
                        t = 1'b1;
                        e = 1'b1;
                        exp_rd = {8'h00, v[7:0]};
                    end
                end
                eq.push_back({1'b1, a, 16'h00FF});
                model_array = 1'b1;
            end
        endcase

        @(negedge clk);
        host_cmd = cmd; host_addr = a; host_wdata = wd; host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        check_val("busy_after_start", 40'(host_busy), 40'd1);
        seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            if (inject && c == 3) begin
                host_cmd = 2'b11; host_addr = 23'h7FFFFF; host_start = 1'b1;
            end else begin
                host_start = 1'b0;
            end
            @(negedge clk);
            if (host_done) seen = 1'b1;
        end
        host_start = 1'b0;
        check_val("done_seen", 40'(seen), 40'd1);
        if (seen) begin
            check_val("busy_at_done", 40'(host_busy), 40'd1);
            check_val("rdata", 40'(host_rdata), 40'(exp_rd));
            check_val("error", 40'(host_error), 40'(e));
            check_val("timeout", 40'(host_timeout), 40'(t));
            @(negedge clk);
            check_val("done_pulse_end", 40'({host_done, host_busy}), 40'd0);
            check_val("op_count", 40'(log_q.size()), 40'(eq.size()));
            for (int i = 0; i < eq.size() && i < log_q.size(); i++)
                check_val("op_word", log_q[i], eq[i]);
        end
    endtask

    initial begin
        int          k, done_cnt;
        logic [1:0]  rc;
        rst = 1'b1; host_cmd = 2'b00; host_addr = 23'd0; host_wdata = 16'h0000; host_start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_ctrl", 40'({host_busy, host_done, host_error, host_timeout, m_req, m_wren}), 40'd0);
        check_val("reset_data", 40'({host_rdata, m_to_mem}), 40'd0);
        check_val("reset_addr", 40'(m_address), 40'd0);
        rst = 1'b0;

        // Directed cases from the command rules.
        dly = 1;
        rsp_q.delete(); rsp_q.push_back(16'hBEEF);
        run_op(2'b00, 23'h000123, 16'h0000, 1'b0);
        rsp_q.delete(); rsp_q.push_back(16'hC0DE);
        run_op(2'b00, 23'h000123, 16'h0000, 1'b0);
        rsp_q.delete(); rsp_q.push_back(16'h0000); rsp_q.push_back(16'h0000); rsp_q.push_back(16'h0080);
        run_op(2'b01, 23'h001000, 16'h1234, 1'b0);
        rsp_q.delete(); rsp_q.push_back(16'h0000); rsp_q.push_back(16'h00A0);
        run_op(2'b10, 23'h020000, 16'h0000, 1'b0);

        // Slow handshake with a start pulse injected while busy.
        dly = 7;
        rsp_q.delete(); rsp_q.push_back(16'h0000); rsp_q.push_back(16'h0080);
        run_op(2'b01, 23'h0ABCDE, 16'h5A5A, 1'b1);

        // Status stuck not-ready: exactly POLL reads, then 0x00FF.
        dly = 0;
        rsp_q.delete();
        run_op(2'b01, 23'h000777, 16'h9999, 1'b0);
        rsp_q.delete();
        run_op(2'b10, 23'h000888, 16'h0000, 1'b0);
        rsp_q.delete(); rsp_q.push_back(16'hAB92);
        run_op(2'b11, 23'h000042, 16'h0000, 1'b0);
        rsp_q.delete(); rsp_q.push_back(16'h0F0F);
        run_op(2'b00, 23'h000042, 16'h0000, 1'b0);

        // Reset mid-PROGRAM while m_req is high.
        dly = 7;
        rsp_q.delete();
        @(negedge clk);
        host_cmd = 2'b01; host_addr = 23'h003000; host_wdata = 16'h4321; host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
        for (k = 0; k < 50 && !m_req; k++) @(negedge clk);
        check_val("req_before_rst", 40'(m_req), 40'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_array = 1'b0;
        check_val("rst_mid_op", 40'({m_req, host_busy, host_done}), 40'd0);
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (host_done) done_cnt++;
        end
        check_val("no_done_after_rst", 40'(done_cnt), 40'd0);
        dly = 2;
        rsp_q.delete(); rsp_q.push_back(16'h5A5A);
        run_op(2'b00, 23'h003000, 16'h0000, 1'b0);

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
            rc = 2'($urandom_range(0, 3));
            dly = $urandom_range(0, 3);
            rsp_q.delete();
            if (rc == 2'b01 || rc == 2'b10) begin
                k = $urandom_range(0, 6);
                for (int j = 0; j < k; j++) rsp_q.push_back(16'($urandom) & 16'hFF7F);
                if ($urandom_range(0, 2) == 0) rsp_q.push_back(16'h0080 | (16'($urandom) & 16'hFF7F));
                else rsp_q.push_back(16'h0080 | (16'($urandom) & 16'hFF45));
            end else begin
                rsp_q.push_back(16'($urandom));
            end
            run_op(rc, 23'($urandom), 16'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
